// File: rtl/exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// exc_commit_ctrl
//   Exception/ERET commit sequencer between writeback and CP0. It picks the
//   committing instruction's exception (plus any pending interrupt), pulses
//   the CP0 exception inputs for the commit cycle, flushes the pipeline, and
//   hands a redirect PC (exception vector or EPC) to fetch over valid/ready.
//   Interrupt recognition is masked for one cycle after an MTC0 commit.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   ws_*             writeback-stage instruction and handshake
//   int_happen       CP0 interrupt-pending qualifier
//   cp0_epc          current CP0 EPC (used as the ERET target)
//   cp0_*            exception inputs to CP0, valid only in the commit cycle
//   flush            kill all younger pipeline stages
//   redirect_*       new fetch PC, valid/ready handshake with fetch
//   exc_count        exceptions + interrupts taken, wraps
// ----------------------------------------------------------------------------
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VEC = 32'hbfc00380,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ws_valid,
  output logic             ws_ready,
  input  logic [31:0]      ws_pc,
  input  logic             ws_is_slot,
  input  logic [7:0]       ws_exc_type,
  input  logic [31:0]      ws_bad_vaddr,
  input  logic             ws_eret,
  input  logic             ws_mtc0,
  input  logic             int_happen,
  input  logic [31:0]      cp0_epc,
  output logic [7:0]       cp0_exc_type,
  output logic [31:0]      cp0_pc,
  output logic             cp0_is_slot,
  output logic [31:0]      cp0_bad_vaddr,
  output logic             cp0_eret,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] exc_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               int_mask_q, int_mask_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   exc_count_q, exc_count_d;

  logic commit;
  logic int_tag;
  logic exc_take;
  logic eret_take;

  // Commit qualification; an exception always beats an ERET on the same instruction.
  always_comb begin
    commit    = ws_valid && (state_q == IDLE);
    int_tag   = int_happen && !int_mask_q;
    exc_take  = commit && ((|ws_exc_type[6:0]) || int_tag);
    eret_take = commit && ws_eret && !exc_take;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (exc_take || eret_take) state_d = REDIR;
      REDIR:   if (redirect_ready)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; CP0 strobes and flush are same-cycle with the commit.
  always_comb begin
    ws_ready       = 1'b0;
    cp0_exc_type   = 8'h00;
    cp0_pc         = 32'h0;
    cp0_is_slot    = 1'b0;
    cp0_bad_vaddr  = 32'h0;
    cp0_eret       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        ws_ready = 1'b1;
        if (commit) begin
          cp0_exc_type  = {int_tag, ws_exc_type[6:0]};
          cp0_pc        = ws_pc;
          cp0_is_slot   = ws_is_slot;
          cp0_bad_vaddr = ws_bad_vaddr;
        end
        cp0_eret = eret_take;
        flush    = exc_take || eret_take;
      end
      REDIR: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
      end
      default: ;
    endcase
    redirect_pc = redirect_pc_q;
    exc_count   = exc_count_q;
  end

  // Datapath next values: redirect target, taken counter, one-shot interrupt mask.
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    exc_count_d   = exc_count_q;
    int_mask_d    = 1'b0;
    if (exc_take) begin
      redirect_pc_d = EXC_VEC;
      exc_count_d   = exc_count_q + CNT_W'(1);
    end else if (eret_take) begin
      redirect_pc_d = cp0_epc;
    end
    // Mask covers a stale int_happen right after a STATUS/CAUSE write.
    if (commit && ws_mtc0 && !exc_take) begin
      int_mask_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_q <= 32'h0;
      exc_count_q   <= '0;
      int_mask_q    <= 1'b0;
    end else begin
      redirect_pc_q <= redirect_pc_d;
      exc_count_q   <= exc_count_d;
      int_mask_q    <= int_mask_d;
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exc_commit_ctrl
//   Directed scenarios followed by random traffic, every output of the DUT
//   checked each cycle against a transaction-level model of the sequencer.
// ----------------------------------------------------------------------------
module tb_exc_commit_ctrl;

  localparam logic [31:0] EXC_VEC = 32'hbfc00380;
  localparam int unsigned CNT_W   = 4;

  logic             clk;
  logic             rst;
  logic             ws_valid;
  logic             ws_ready;
  logic [31:0]      ws_pc;
  logic             ws_is_slot;
  logic [7:0]       ws_exc_type;
  logic [31:0]      ws_bad_vaddr;
  logic             ws_eret;
  logic             ws_mtc0;
  logic             int_happen;
  logic [31:0]      cp0_epc;
  logic [7:0]       cp0_exc_type;
  logic [31:0]      cp0_pc;
  logic             cp0_is_slot;
  logic [31:0]      cp0_bad_vaddr;
  logic             cp0_eret;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic [CNT_W-1:0] exc_count;

  exc_commit_ctrl #(.EXC_VEC(EXC_VEC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc),
    .ws_is_slot(ws_is_slot), .ws_exc_type(ws_exc_type),
    .ws_bad_vaddr(ws_bad_vaddr), .ws_eret(ws_eret), .ws_mtc0(ws_mtc0),
    .int_happen(int_happen), .cp0_epc(cp0_epc),
    .cp0_exc_type(cp0_exc_type), .cp0_pc(cp0_pc), .cp0_is_slot(cp0_is_slot),
    .cp0_bad_vaddr(cp0_bad_vaddr), .cp0_eret(cp0_eret), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_count(exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Model: a pending redirect (if any), taken count, and one-cycle interrupt mask.
  bit          m_busy;
  logic [31:0] m_target;
  int unsigned m_taken;
  bit          m_masked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_wb(input bit v, input logic [31:0] pc, input bit slot,
                        input logic [7:0] et, input logic [31:0] bad,
                        input bit er, input bit mt);
    ws_valid = v; ws_pc = pc; ws_is_slot = slot; ws_exc_type = et;
    ws_bad_vaddr = bad; ws_eret = er; ws_mtc0 = mt;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    bit          accepted, intr, exc, eret;
    logic [7:0]  e_type;
    @(negedge clk);
    accepted = !m_busy && ws_valid;
    intr     = int_happen && !m_masked;
    exc      = accepted && ((ws_exc_type & 8'h7f) != 8'h00 || intr);
    eret     = accepted && ws_eret && !exc;
    e_type   = accepted ? ((ws_exc_type & 8'h7f) | (intr ? 8'h80 : 8'h00)) : 8'h00;
    chk("ws_ready",       32'(ws_ready),       32'(!m_busy));
    chk("cp0_exc_type",   32'(cp0_exc_type),   32'(e_type));
    chk("cp0_pc",         cp0_pc,              accepted ? ws_pc : 32'h0);
    chk("cp0_is_slot",    32'(cp0_is_slot),    32'(accepted && ws_is_slot));
    chk("cp0_bad_vaddr",  cp0_bad_vaddr,       accepted ? ws_bad_vaddr : 32'h0);
    chk("cp0_eret",       32'(cp0_eret),       32'(eret));
    chk("flush",          32'(flush),          32'(m_busy || exc || eret));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_busy));
    chk("redirect_pc",    redirect_pc,         m_target);
    chk("exc_count",      32'(exc_count),      m_taken);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_target = 32'h0; m_taken = 0; m_masked = 0;
    end else if (m_busy) begin
      if (redirect_ready) m_busy = 0;
      m_masked = 0;
    end else begin
      if (exc) begin
        m_busy = 1; m_target = EXC_VEC; m_taken = (m_taken + 1) % 16;
      end else if (eret) begin
        m_busy = 1; m_target = cp0_epc;
      end
      m_masked = accepted && ws_mtc0 && !exc;
    end
    #1;
  endtask

  initial begin
    int unsigned saved;
    rst = 1'b1; redirect_ready = 1'b1; int_happen = 1'b0; cp0_epc = 32'h0;
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_busy = 0; m_target = 32'h0; m_taken = 0; m_masked = 0;
    cycle();  // reset state

    // 1: syscall
    set_wb(1, 32'hbfc00100, 0, 8'h08, 32'h0, 0, 0);
    cycle();
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle(); cycle();

    // 2: ERET
    cp0_epc = 32'hbfc00200;
    set_wb(1, 32'hbfc00300, 0, 8'h00, 32'h0, 1, 0);
    cycle();
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle(); cycle();

    // 3: interrupt on a plain instruction (in a delay slot)
    int_happen = 1'b1;
    set_wb(1, 32'hbfc00400, 1, 8'h00, 32'h1234, 0, 0);
    cycle();
    int_happen = 1'b0;
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle(); cycle();

    // 4: MTC0 masks the interrupt for the next commit only
    set_wb(1, 32'hbfc00500, 0, 8'h00, 32'h0, 0, 1);
    cycle();
    int_happen = 1'b1;
    set_wb(1, 32'hbfc00504, 0, 8'h00, 32'h0, 0, 0);
    cycle();
    set_wb(1, 32'hbfc00508, 0, 8'h00, 32'h0, 0, 0);
    cycle();
    int_happen = 1'b0;
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle(); cycle();

    // 5: back-pressure with an ignored WB instruction
    set_wb(1, 32'hbfc00600, 0, 8'h20, 32'h0, 0, 0);
    cycle();
    redirect_ready = 1'b0;
    set_wb(1, 32'hbfc00604, 0, 8'h01, 32'h0, 0, 0);
    repeat (5) cycle();
    redirect_ready = 1'b1;
    cycle();
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle();

    // 6: ERET with ades -> exception wins
    set_wb(1, 32'hbfc00700, 0, 8'h10, 32'hdeadbeef, 1, 0);
    cycle();
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    cycle(); cycle();

    // 7: 16 exceptions wrap a 4-bit counter back to its start value
    saved = 32'(exc_count);
    for (int i = 0; i < 16; i++) begin
      set_wb(1, 32'hbfc00800 + 32'(i * 4), 0, 8'h04, 32'h0, 0, 0);
      cycle();
      set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
      cycle();
    end
    chk("exc_count_wrap", 32'(exc_count), saved);

    // 8: reset while redirecting
    set_wb(1, 32'hbfc00900, 0, 8'h02, 32'h0, 0, 0);
    cycle();
    set_wb(0, 32'h0, 0, 8'h00, 32'h0, 0, 0);
    redirect_ready = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_redir_pc", redirect_pc, 32'h0);
    redirect_ready = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] et;
      et = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      set_wb(bit'($urandom_range(0, 3) != 0), $urandom, bit'($urandom_range(0, 1)),
             et, $urandom, bit'($urandom_range(0, 4) == 0),
             bit'($urandom_range(0, 4) == 0));
      int_happen     = ($urandom_range(0, 4) == 0);
      cp0_epc        = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      rst            = ($urandom_range(0, 49) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
